uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter BIT_CYCLES, default 5248, is the number of sysclk cycles per serial bit (16 x 328 sysclk, which matches the 16x oversample baud tick); legal range 2..8191.
REQ-002 sysclk  in  1  system clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low; low forces the reset state immediately.
REQ-004 req0  in  1  requester 0 wants to send a byte; held until gnt0.
REQ-005 data0  in  8  requester 0 byte; stable while req0 is high.
REQ-006 gnt0  out  1  one-cycle pulse; requester 0's byte accepted.
REQ-007 req1  in  1  requester 1 request; same rules as req0.
REQ-008 data1  in  8  requester 1 byte; stable while req1 is high.
REQ-009 gnt1  out  1  one-cycle pulse; requester 1's byte accepted.
REQ-010 tx  out  1  serial line; registered; idle high.
REQ-011 busy  out  1  high while the FSM is in any state other than IDLE.
REQ-012 done  out  1  one-cycle pulse when a frame's stop bit has completed.
REQ-013 last_src  out  1  index of the requester granted most recently.

Function
REQ-014 FSM states: IDLE, START, DATA, STOP; all are registered.
REQ-015 Internal counters:
- bit-cycle counter: 13 bits, counts 0..BIT_CYCLES-1, wraps to 0.
- bit index: 3 bits.
- round-robin pointer rr: 1 bit.
REQ-016 Arbitration in IDLE: at a rising edge with state==IDLE and at least one req high, a requester is chosen.
- Only one req high: that requester wins.
- Both req high: the requester != rr wins.
REQ-017 On that edge:
- the winner's data is latched into an 8-bit shift register;
- rr <= winner and last_src <= winner;
- gnt_winner goes high for exactly one cycle (the first START cycle);
- state <= START.
REQ-018 gnt0 and gnt1 are never high in the same cycle, and neither is asserted outside the first START cycle.
REQ-019 A req that stays high after its grant is ignored until the FSM has returned to IDLE, where it is re-arbitrated normally.
REQ-020 tx by state:
- START: 0.
- DATA: shift register bit 0, sent LSB first.
- STOP and IDLE: 1.
Each bit lasts exactly BIT_CYCLES cycles.
REQ-021 Bit timing:
- START -> DATA when the bit-cycle counter wraps.
- In DATA the shift register shifts right on each wrap; after the 8th wrap (bit index 7) state <= STOP.
- STOP -> IDLE on wrap.
REQ-022 Frame length: exactly 10*BIT_CYCLES cycles from the first START cycle to the last STOP cycle.
REQ-023 done is high for exactly the first IDLE cycle after STOP.
REQ-024 Back-to-back frames: if a req is high in that first IDLE cycle, the next START begins one cycle later, giving exactly one extra idle-high cycle between frames.
REQ-025 req and data changes during START, DATA or STOP do not affect the frame in progress.
REQ-026 busy is high exactly when state != IDLE; it is low in the done cycle.
REQ-027 The bit-cycle counter is held at 0 in IDLE; no other counter advances in IDLE.

Reset
REQ-028 While reset is low:
- state=IDLE, tx=1, busy=0, done=0, gnt0=0, gnt1=0;
- last_src=0, rr=1 (so requester 0 wins the first tie);
- all counters and the shift register are 0.
REQ-029 Reset asserted mid-frame aborts the frame immediately (tx=1 asynchronously) and produces no done pulse.
REQ-030 After reset deasserts, the first rising edge with a req high performs arbitration normally.

Verification (BIT_CYCLES=4 in simulation)
REQ-031 Single send: req0=1, data0=0xA5 in IDLE.
- Expected: gnt0 for 1 cycle; tx = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total); done on cycle 41; last_src=0.
REQ-032 Tie after reset: req0=req1=1, data0=0x01, data1=0x80, both held until their own grant.
- Expected: gnt0 first and frame 0x01; 1 idle cycle; then gnt1 and frame 0x80; last_src=1.
REQ-033 Round-robin fairness: both req held high continuously.
- Expected: grants alternate 0,1,0,1; no requester gets two consecutive grants.
REQ-034 Mid-frame change: during a frame, data0 changes and req1 rises.
- Expected: the in-flight frame bits are unchanged; gnt1 occurs only after done.
REQ-035 Mid-frame reset: reset pulsed low during the DATA bit 3.
- Expected: tx=1 immediately; busy=0; no done; a new req0 afterwards yields a full, correct frame.

Source files
------------

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - two-requester round-robin UART transmit scheduler
module uart_tx_sched #(
    parameter int BIT_CYCLES = 5248
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       gnt0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       gnt1,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       last_src
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [12:0] LAST_CYCLE = 13'(BIT_CYCLES - 1);

    state_t      state;
    logic [12:0] cnt;
    logic [2:0]  bit_idx;
    logic        rr;
    logic [7:0]  shreg;
    logic        wrap;
    logic        any_req;
    logic        winner;

    always_comb begin
        wrap    = (cnt == LAST_CYCLE);
        any_req = req0 | req1;
        // On a tie the requester that did not win last time goes next.
        winner  = (req0 & req1) ? ~rr : req1;
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            rr       <= 1'b1;
            shreg    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            last_src <= 1'b0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (any_req) begin
                        shreg    <= winner ? data1 : data0;
                        rr       <= winner;
                        last_src <= winner;
                        gnt0     <= ~winner;
                        gnt1     <= winner;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (wrap) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                        state   <= DATA;
                    end else begin
                        cnt <= cnt + 13'd1;
                    end
                end
                DATA: begin
                    if (wrap) begin
                        cnt   <= '0;
                        shreg <= {1'b0, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + 13'd1;
                    end
                end
                STOP: begin
                    if (wrap) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        tx    <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 13'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - self-checking bench for uart_tx_sched
module tb_uart_tx_sched;

    localparam int BC = 4;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b0;
    logic       req0   = 1'b0;
    logic       req1   = 1'b0;
    logic [7:0] data0  = 8'h00;
    logic [7:0] data1  = 8'h00;
    logic       gnt0, gnt1, tx, busy, done, last_src;

    int checks = 0;
    int errors = 0;

    uart_tx_sched #(.BIT_CYCLES(BC)) dut (
        .sysclk(sysclk), .reset(reset),
        .req0(req0), .data0(data0), .gnt0(gnt0),
        .req1(req1), .data1(data1), .gnt1(gnt1),
        .tx(tx), .busy(busy), .done(done), .last_src(last_src)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: time since frame start decides the line level directly.
    bit       m_active = 1'b0;
    int       m_t      = 0;
    bit [7:0] m_byte   = 8'h00;
    bit       m_src    = 1'b0;
    bit       m_rr     = 1'b1;
    bit       m_last   = 1'b0;
    bit       m_done   = 1'b0;

    always @(posedge sysclk) begin
        if (!reset) begin
            m_active = 1'b0;
            m_t      = 0;
            m_rr     = 1'b1;
            m_last   = 1'b0;
            m_done   = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_active) begin
                m_t++;
                if (m_t == 10 * BC) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end else if (req0 || req1) begin
                m_src    = (req0 && req1) ? !m_rr : req1;
                m_byte   = m_src ? data1 : data0;
                m_rr     = m_src;
                m_last   = m_src;
                m_active = 1'b1;
                m_t      = 0;
            end
        end
    end

    function automatic bit model_tx();
        int b;
        if (!m_active) return 1'b1;
        b = m_t / BC;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_byte[b-1];
        return 1'b1;
    endfunction

    always @(negedge sysclk) begin
        chk("tx",       32'(tx),       32'(model_tx()));
        chk("busy",     32'(busy),     32'(m_active));
        chk("done",     32'(done),     32'(m_done));
        chk("gnt0",     32'(gnt0),     32'(m_active && m_t == 0 && !m_src));
        chk("gnt1",     32'(gnt1),     32'(m_active && m_t == 0 && m_src));
        chk("last_src", 32'(last_src), 32'(m_last));
    end

    // sel: 0 gnt0, 1 gnt1, 2 done, 3 any grant; returns on the negedge where seen
    task automatic wait_evt(input int sel, input int budget, input string name, output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            @(negedge sysclk);
            cycles++;
            case (sel)
                0: seen = gnt0;
                1: seen = gnt1;
                2: seen = done;
                default: seen = gnt0 | gnt1;
            endcase
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: event not seen within %0d cycles", name, budget);
        end
    endtask

    initial begin
        int       n;
        bit       seen_gnt1;
        bit [9:0] frame_a5;

        repeat (2) @(negedge sysclk);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_last_src", 32'(last_src), 32'd0);
        reset = 1'b1;
        @(negedge sysclk);

        // Single send of 0xA5: start, LSB-first data, stop
        frame_a5 = 10'b11_0100_1010;
        data0 = 8'hA5;
        req0  = 1'b1;
        @(negedge sysclk);
        chk("single_gnt0", 32'(gnt0), 32'd1);
        req0 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if ((c - 1) % BC == 0) chk("single_bit", 32'(tx), 32'(frame_a5[(c-1)/BC]));
            @(negedge sysclk);
        end
        chk("single_done_c41", 32'(done), 32'd1);
        chk("single_busy_c41", 32'(busy), 32'd0);
        repeat (3) @(negedge sysclk);

        // Tie straight after reset: requester 0 first, then 1 after one idle cycle
        reset = 1'b0;
        @(negedge sysclk);
        reset = 1'b1;
        data0 = 8'h01;
        data1 = 8'h80;
        req0  = 1'b1;
        req1  = 1'b1;
        wait_evt(0, 5, "tie_gnt0", n);
        req0 = 1'b0;
        wait_evt(1, 60, "tie_gnt1", n);
        chk("tie_gap", 32'(n), 32'd41);
        req1 = 1'b0;
        wait_evt(2, 60, "tie_done", n);
        chk("tie_last_src", 32'(last_src), 32'd1);

        // Continuous contention alternates grants
        data0 = 8'h3C;
        data1 = 8'hC5;
        req0  = 1'b1;
        req1  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_evt(3, 60, "rr_gnt", n);
            chk("rr_order", 32'(gnt1), 32'(k % 2));
        end
        req0 = 1'b0;
        req1 = 1'b0;
        wait_evt(2, 60, "rr_done", n);

        // Mid-frame input changes must not disturb the frame in flight
        data0 = 8'h3C;
        req0  = 1'b1;
        wait_evt(0, 5, "mid_gnt0", n);
        req0 = 1'b0;
        repeat (10) @(negedge sysclk);
        data0 = 8'hFF;
        data1 = 8'h55;
        req1  = 1'b1;
        seen_gnt1 = 1'b0;
        n = 0;
        while (!done && n < 60) begin
            @(negedge sysclk);
            n++;
            if (gnt1) seen_gnt1 = 1'b1;
        end
        chk("mid_done_seen", 32'(done), 32'd1);
        chk("mid_no_early_gnt1", 32'(seen_gnt1), 32'd0);
        @(negedge sysclk);
        chk("mid_gnt1_after_done", 32'(gnt1), 32'd1);
        req1 = 1'b0;
        wait_evt(2, 60, "mid_done2", n);

        // Reset during data bit 3 of 0xC3 (that bit is 0)
        data0 = 8'hC3;
        req0  = 1'b1;
        wait_evt(0, 5, "rst_gnt0", n);
        req0 = 1'b0;
        repeat (17) @(negedge sysclk);
        chk("rst_pre_tx", 32'(tx), 32'd0);
        #1 reset = 1'b0;
        #1;
        chk("rst_async_tx", 32'(tx), 32'd1);
        chk("rst_async_busy", 32'(busy), 32'd0);
        chk("rst_async_done", 32'(done), 32'd0);
        @(negedge sysclk);
        reset = 1'b1;
        repeat (3) @(negedge sysclk);
        data0 = 8'h5A;
        req0  = 1'b1;
        wait_evt(0, 5, "post_rst_gnt0", n);
        req0 = 1'b0;
        wait_evt(2, 60, "post_rst_done", n);
        chk("post_rst_frame_len", 32'(n), 32'd40);
        chk("post_rst_last_src", 32'(last_src), 32'd0);
        repeat (2) @(negedge sysclk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
